// File: rtl/pipeline_ctrl_pkg.sv
// Shared FSM state encodings and forwarding-select constants for the
// pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_MULDIV = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational source/destination comparator: operand forwarding selects
// for the ID-stage muxes and load-use hazard detection.
module hazard_forward_unit (
  input  logic [4:0] idRs_i,
  input  logic [4:0] idRt_i,
  input  logic       idUsesRs_i,
  input  logic       idUsesRt_i,
  input  logic [4:0] exReg_i,
  input  logic       exRfEnable_i,
  input  logic       exLoad_i,
  input  logic [4:0] memReg_i,
  input  logic       memRfEnable_i,
  input  logic [4:0] wbReg_i,
  input  logic       wbRfEnable_i,
  output logic [1:0] fwdASel_o,
  output logic [1:0] fwdBSel_o,
  output logic       loadUse_o
);
  import pipeline_ctrl_pkg::*;

  // A load in EX has no data yet, so it is never a forwarding source.
  function automatic logic [1:0] pickSource(
    input logic [4:0] src,
    input logic       uses,
    input logic [4:0] exReg,
    input logic       exFwdOk,
    input logic [4:0] memReg,
    input logic       memEn,
    input logic [4:0] wbReg,
    input logic       wbEn
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (uses && (src != 5'd0)) begin
      if (exFwdOk && (exReg == src))       sel = FWD_EX;
      else if (memEn && (memReg == src))   sel = FWD_MEM;
      else if (wbEn && (wbReg == src))     sel = FWD_WB;
    end
    return sel;
  endfunction

  logic exFwdOk;
  logic rsHit;
  logic rtHit;

  assign exFwdOk = exRfEnable_i && !exLoad_i;
  assign rsHit   = idUsesRs_i && (idRs_i == exReg_i);
  assign rtHit   = idUsesRt_i && (idRt_i == exReg_i);

  always_comb begin
    fwdASel_o = pickSource(idRs_i, idUsesRs_i, exReg_i, exFwdOk,
                           memReg_i, memRfEnable_i, wbReg_i, wbRfEnable_i);
    fwdBSel_o = pickSource(idRt_i, idUsesRt_i, exReg_i, exFwdOk,
                           memReg_i, memRfEnable_i, wbReg_i, wbRfEnable_i);
    loadUse_o = exLoad_i && exRfEnable_i && (exReg_i != 5'd0) && (rsHit || rtHit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush/forward controller with post-reset drain and HI/LO
// mul/div freeze. Define HAZARD_PERF_CNT_EN to add the STALL_COUNT counter.
module pipeline_hazard_controller #(
  parameter int INIT_CYCLES   = 4,
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_USES_RS,
  input  logic        ID_USES_RT,
  input  logic        ID_BRANCH_TAKEN,
  input  logic        ID_MULDIV_START,
  input  logic [4:0]  EX_REG,
  input  logic        EX_RF_ENABLE,
  input  logic        EX_LOAD_INSTR,
  input  logic [4:0]  MEM_REG,
  input  logic        MEM_RF_ENABLE,
  input  logic [4:0]  WB_REG,
  input  logic        WB_RF_ENABLE,
  output logic        PC_LE,
  output logic        IF_ID_LE,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_NOP,
  output logic [1:0]  FWD_A_SEL,
  output logic [1:0]  FWD_B_SEL,
  output logic        BUSY
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] STALL_COUNT
`endif
);
  import pipeline_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic             loadUse;

  hazard_forward_unit uFwd (
    .idRs_i        (ID_RS),
    .idRt_i        (ID_RT),
    .idUsesRs_i    (ID_USES_RS),
    .idUsesRt_i    (ID_USES_RT),
    .exReg_i       (EX_REG),
    .exRfEnable_i  (EX_RF_ENABLE),
    .exLoad_i      (EX_LOAD_INSTR),
    .memReg_i      (MEM_REG),
    .memRfEnable_i (MEM_RF_ENABLE),
    .wbReg_i       (WB_REG),
    .wbRfEnable_i  (WB_RF_ENABLE),
    .fwdASel_o     (fwdA),
    .fwdBSel_o     (fwdB),
    .loadUse_o     (loadUse)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_INIT;
      cnt_q   <= CNT_W'(INIT_CYCLES - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RUN: begin
        if (ID_MULDIV_START && !loadUse) begin
          state_d = ST_MULDIV;
          cnt_d   = CNT_W'(MULDIV_CYCLES - 2);
        end
      end
      ST_MULDIV: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = CNT_W'(INIT_CYCLES - 1);
      end
    endcase
  end

  // A held reset forces the drain pattern even before the first edge lands.
  always_comb begin
    PC_LE       = 1'b1;
    IF_ID_LE    = 1'b1;
    IF_ID_FLUSH = 1'b0;
    ID_EX_NOP   = 1'b0;
    FWD_A_SEL   = fwdA;
    FWD_B_SEL   = fwdB;
    BUSY        = 1'b0;
    if (!Reset || (state_q != ST_RUN && state_q != ST_MULDIV)) begin
      PC_LE       = 1'b0;
      IF_ID_LE    = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_NOP   = 1'b1;
      FWD_A_SEL   = FWD_RF;
      FWD_B_SEL   = FWD_RF;
      BUSY        = 1'b1;
    end else if (state_q == ST_MULDIV) begin
      PC_LE     = 1'b0;
      IF_ID_LE  = 1'b0;
      ID_EX_NOP = 1'b1;
      BUSY      = 1'b1;
    end else if (loadUse) begin
      PC_LE     = 1'b0;
      IF_ID_LE  = 1'b0;
      ID_EX_NOP = 1'b1;
    end else if (ID_BRANCH_TAKEN) begin
      IF_ID_FLUSH = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt_q, stallCnt_d;

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (Reset && (state_q == ST_RUN || state_q == ST_MULDIV) && !PC_LE
        && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) stallCnt_q <= 32'd0;
    else        stallCnt_q <= stallCnt_d;
  end

  assign STALL_COUNT = stallCnt_q;
`endif

endmodule
